// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: a CPU-side bus controller that splits accesses between a
// word-wide RAM (1-cycle read latency) and a byte-wide IO window at the top
// of the address space.
// Sequence per access: IDLE -> RAM | IO -> DONE -> IDLE, with a one-cycle
// ready pulse in DONE.
// Optional feature macro: MEM_BUS_ALIGN_CHK_EN. When it is defined, a word
// access to an odd address is rejected with an err pulse. When it is not
// defined there is no err port, and addr[0] is ignored for word accesses.
module mem_bus_ctrl #(
    parameter int unsigned DW      = 16,
    parameter int unsigned AW      = 16,
    parameter int unsigned IO_BASE = 'hFF80,
    parameter int unsigned IO_WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    // CPU side
    input  logic          req_i,
    input  logic          we_i,
    input  logic          be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          ready_o,
`ifdef MEM_BUS_ALIGN_CHK_EN
    output logic          err_o,
`endif
    // RAM side
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic [1:0]    ram_be_o,
    output logic          ram_we_o,
    output logic          ram_re_o,
    // IO side
    output logic [2:0]    io_addr_o,
    output logic [7:0]    io_wdata_o,
    input  logic [7:0]    io_rdata_i,
    output logic          io_ce_o,
    output logic          io_we_o,
    output logic          io_re_o
);

    localparam logic [AW-1:0] IO_BASE_A = AW'(IO_BASE);
    localparam logic [3:0]    IO_WAIT_W = 4'(IO_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAM  = 2'd1,
        S_IO   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          we_q,    we_d;
    logic          be_q,    be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    wait_q,  wait_d;
    logic [DW-1:0] rdata_q, rdata_d;
`ifdef MEM_BUS_ALIGN_CHK_EN
    logic          err_q,   err_d;
`endif

    // Read value as the CPU sees it: selected byte lane zero-extended, or the whole word.
    logic [DW-1:0] ram_rd_val;

    // FSM state register; reset returns to IDLE immediately, even mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields, IO wait counter and read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 1'b0;
            wdata_q <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
`ifdef MEM_BUS_ALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
`ifdef MEM_BUS_ALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Byte lane steering for RAM reads: odd byte address is the low lane, even is the high lane.
    always_comb begin
        ram_rd_val = '0;
        if (be_q) begin
            if (addr_q[0]) begin
                ram_rd_val[7:0] = ram_rdata_i[7:0];
            end else begin
                ram_rd_val[7:0] = ram_rdata_i[15:8];
            end
        end else begin
            ram_rd_val = ram_rdata_i;
        end
    end

    // Next-state logic: accept in IDLE, one RAM cycle, IO_WAIT+1 IO cycles, one DONE cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
`ifdef MEM_BUS_ALIGN_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    wait_d  = IO_WAIT_W;
`ifdef MEM_BUS_ALIGN_CHK_EN
                    err_d   = 1'b0;
                    // Misaligned word access: complete at once with err, touch nothing.
                    if (!be_i && addr_i[0]) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else
`endif
                    if (addr_i >= IO_BASE_A) begin
                        state_d = S_IO;
                    end else begin
                        state_d = S_RAM;
                    end
                end
            end
            S_RAM: begin
                state_d = S_DONE;
                if (!we_q) begin
                    rdata_d = ram_rd_val;
                end
            end
            S_IO: begin
                if (wait_q == 4'd0) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d      = '0;
                        rdata_d[7:0] = io_rdata_i;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: strobes decoded from state, data paths driven from latched fields.
    always_comb begin
        ram_addr_o  = {1'b0, addr_q[AW-1:1]};
        ram_wdata_o = '0;
        ram_be_o    = 2'b00;
        ram_we_o    = 1'b0;
        ram_re_o    = 1'b0;
        io_addr_o   = addr_q[2:0];
        io_wdata_o  = wdata_q[7:0];
        io_ce_o     = 1'b0;
        io_we_o     = 1'b0;
        io_re_o     = 1'b0;
        ready_o     = 1'b0;
        rdata_o     = rdata_q;
`ifdef MEM_BUS_ALIGN_CHK_EN
        err_o       = 1'b0;
`endif
        // Write data lane placement mirrors the read lane selection.
        if (be_q) begin
            if (addr_q[0]) begin
                ram_wdata_o[7:0]  = wdata_q[7:0];
            end else begin
                ram_wdata_o[15:8] = wdata_q[7:0];
            end
        end else begin
            ram_wdata_o = wdata_q;
        end
        case (state_q)
            S_RAM: begin
                ram_we_o = we_q;
                ram_re_o = !we_q;
                if (be_q) begin
                    ram_be_o = addr_q[0] ? 2'b01 : 2'b10;
                end else begin
                    ram_be_o = 2'b11;
                end
            end
            S_IO: begin
                io_ce_o = 1'b1;
                io_we_o = we_q;
                io_re_o = !we_q;
            end
            S_DONE: begin
                ready_o = 1'b1;
`ifdef MEM_BUS_ALIGN_CHK_EN
                err_o   = err_q;
`endif
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed testbench for mem_bus_ctrl (default parameters, IO_WAIT=2).
// RAM and IO read data are driven directly by the bench per vector.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic        be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
`ifdef MEM_BUS_ALIGN_CHK_EN
    logic        err;
`endif
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [1:0]  ram_be;
    logic        ram_we;
    logic        ram_re;
    logic [2:0]  io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        io_ce;
    logic        io_we;
    logic        io_re;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the last access
    int          lat;
    int          ce_cnt;
    int          ram_hits;
    logic [15:0] s_ram_addr;
    logic [15:0] s_ram_wdata;
    logic [1:0]  s_ram_be;
    logic        s_ram_we;
    logic        s_ram_re;
    logic [2:0]  s_io_addr;
    logic [7:0]  s_io_wdata;
    logic        s_io_we;
    logic        s_io_re;
    logic        s_err;

    mem_bus_ctrl #(
        .DW(16), .AW(16), .IO_BASE('hFF80), .IO_WAIT(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .we_i        (we),
        .be_i        (be),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .ready_o     (ready),
`ifdef MEM_BUS_ALIGN_CHK_EN
        .err_o       (err),
`endif
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .ram_be_o    (ram_be),
        .ram_we_o    (ram_we),
        .ram_re_o    (ram_re),
        .io_addr_o   (io_addr),
        .io_wdata_o  (io_wdata),
        .io_rdata_i  (io_rdata),
        .io_ce_o     (io_ce),
        .io_we_o     (io_we),
        .io_re_o     (io_re)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CPU access; records strobes seen and the latency in cycles from accept to ready.
    task automatic access(input logic [15:0] a, input logic w, input logic b, input logic [15:0] d);
        @(negedge clk);
        addr  = a;
        we    = w;
        be    = b;
        wdata = d;
        req   = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; ce_cnt = 0; ram_hits = 0;
        s_ram_addr = '0; s_ram_wdata = '0; s_ram_be = '0; s_ram_we = 0; s_ram_re = 0;
        s_io_addr = '0; s_io_wdata = '0; s_io_we = 0; s_io_re = 0; s_err = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (io_ce) begin
                ce_cnt++;
                s_io_addr  = io_addr;
                s_io_wdata = io_wdata;
                s_io_we    = io_we;
                s_io_re    = io_re;
            end
            if (ram_re || ram_we) begin
                ram_hits++;
                s_ram_addr  = ram_addr;
                s_ram_wdata = ram_wdata;
                s_ram_be    = ram_be;
                s_ram_we    = ram_we;
                s_ram_re    = ram_re;
            end
            if (ready) begin
                lat = i;
`ifdef MEM_BUS_ALIGN_CHK_EN
                s_err = err;
`endif
                break;
            end
        end
        $display("access addr=0x%04h we=%0b be=%0b wdata=0x%04h lat=%0d rdata=0x%04h",
                 a, w, b, d, lat, rdata);
    endtask

    initial begin
        rst_n = 1'b0; req = 0; we = 0; be = 0; addr = '0; wdata = '0;
        ram_rdata = '0; io_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdata",  32'(rdata),  32'h0);
        check_eq("rst_ready",  32'(ready),  32'h0);
        check_eq("rst_ram_be", 32'(ram_be), 32'h0);
        check_eq("rst_strobe", 32'({ram_re, ram_we, io_ce, io_we, io_re}), 32'h0);
        rst_n = 1'b1;

        // Word write 0x1234 to 0x0010
        access(16'h0010, 1'b1, 1'b0, 16'h1234);
        check_eq("ww_lat",   lat, 2);
        check_eq("ww_addr",  32'(s_ram_addr),  32'h0008);
        check_eq("ww_be",    32'(s_ram_be),    32'h3);
        check_eq("ww_wdata", 32'(s_ram_wdata), 32'h1234);
        check_eq("ww_we",    32'({s_ram_we, s_ram_re}), 32'h2);
        check_eq("ww_noio",  ce_cnt, 0);

        // Word read 0x0010
        ram_rdata = 16'h1234;
        access(16'h0010, 1'b0, 1'b0, 16'h0000);
        check_eq("wr_lat",   lat, 2);
        check_eq("wr_addr",  32'(s_ram_addr), 32'h0008);
        check_eq("wr_be",    32'(s_ram_be),   32'h3);
        check_eq("wr_re",    32'({s_ram_we, s_ram_re}), 32'h1);
        check_eq("wr_rdata", 32'(rdata), 32'h1234);

        // Byte write 0xAB to odd address 0x0011
        ram_rdata = 16'hFFFF;
        access(16'h0011, 1'b1, 1'b1, 16'hCDAB);
        check_eq("bwo_be",    32'(s_ram_be),    32'h1);
        check_eq("bwo_wdata", 32'(s_ram_wdata), 32'h00AB);
        check_eq("bwo_rdata_hold", 32'(rdata),  32'h1234);

        // Byte write 0x5A to even address 0x0010
        access(16'h0010, 1'b1, 1'b1, 16'h775A);
        check_eq("bwe_be",    32'(s_ram_be),    32'h2);
        check_eq("bwe_wdata", 32'(s_ram_wdata), 32'h5A00);
        check_eq("bwe_rdata_hold", 32'(rdata),  32'h1234);

        // Byte reads of RAM word 0x56AB
        ram_rdata = 16'h56AB;
        access(16'h0011, 1'b0, 1'b1, 16'h0000);
        check_eq("bro_be",    32'(s_ram_be), 32'h1);
        check_eq("bro_rdata", 32'(rdata),    32'h00AB);
        access(16'h0010, 1'b0, 1'b1, 16'h0000);
        check_eq("bre_be",    32'(s_ram_be), 32'h2);
        check_eq("bre_rdata", 32'(rdata),    32'h0056);

        // IO read 0xFF85
        io_rdata = 8'h7E;
        access(16'hFF85, 1'b0, 1'b0, 16'h0000);
        check_eq("ior_lat",   lat, 4);
        check_eq("ior_ce",    ce_cnt, 3);
        check_eq("ior_addr",  32'(s_io_addr), 32'h5);
        check_eq("ior_re",    32'({s_io_we, s_io_re}), 32'h1);
        check_eq("ior_noram", ram_hits, 0);
        check_eq("ior_rdata", 32'(rdata), 32'h007E);

        // IO write at IO_BASE, word access still writes one byte
        access(16'hFF80, 1'b1, 1'b0, 16'h12C3);
        check_eq("iow_lat",   lat, 4);
        check_eq("iow_wdata", 32'(s_io_wdata), 32'hC3);
        check_eq("iow_we",    32'({s_io_we, s_io_re}), 32'h2);
        check_eq("iow_addr",  32'(s_io_addr), 32'h0);
        check_eq("iow_rdata_hold", 32'(rdata), 32'h007E);

        // IO_BASE-1 is RAM
        access(16'hFF7F, 1'b0, 1'b1, 16'h0000);
        check_eq("edge_ram_lat",  lat, 2);
        check_eq("edge_ram_addr", 32'(s_ram_addr), 32'h7FBF);
        check_eq("edge_ram_noio", ce_cnt, 0);
        check_eq("edge_ram_rd",   32'(rdata), 32'h00AB);

        // Top address is IO
        io_rdata = 8'h81;
        access(16'hFFFF, 1'b0, 1'b1, 16'h0000);
        check_eq("top_io_lat",   lat, 4);
        check_eq("top_io_addr",  32'(s_io_addr), 32'h7);
        check_eq("top_io_rdata", 32'(rdata), 32'h0081);

        // Word read at odd address
        ram_rdata = 16'h4321;
        access(16'h0003, 1'b0, 1'b0, 16'h0000);
`ifdef MEM_BUS_ALIGN_CHK_EN
        check_eq("mis_lat",   lat, 1);
        check_eq("mis_err",   32'(s_err), 32'h1);
        check_eq("mis_noram", ram_hits, 0);
        check_eq("mis_rdata", 32'(rdata), 32'h0081);
`else
        check_eq("odd_lat",   lat, 2);
        check_eq("odd_addr",  32'(s_ram_addr), 32'h0001);
        check_eq("odd_be",    32'(s_ram_be), 32'h3);
        check_eq("odd_rdata", 32'(rdata), 32'h4321);
`endif

        // Reset in the second IO cycle
        io_rdata = 8'h33;
        @(negedge clk);
        addr = 16'hFF85; we = 1'b0; be = 1'b0; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ce",    32'(io_ce), 32'h0);
        check_eq("rst_mid_ready", 32'(ready), 32'h0);
        check_eq("rst_mid_rdata", 32'(rdata), 32'h0);
        $display("reset asserted mid-IO: io_ce=%0b ready=%0b rdata=0x%04h", io_ce, ready, rdata);
        @(negedge clk);
        rst_n = 1'b1;
        ram_rdata = 16'h9ABC;
        access(16'h0020, 1'b0, 1'b0, 16'h0000);
        check_eq("post_rst_lat",   lat, 2);
        check_eq("post_rst_addr",  32'(s_ram_addr), 32'h0010);
        check_eq("post_rst_rdata", 32'(rdata), 32'h9ABC);

        @(negedge clk);
        check_eq("idle_ready_low", 32'(ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter DW, default 16: CPU/RAM data width; even, >=16.
REQ-002 Parameter AW, default 16: CPU byte-address width.
REQ-003 Parameter IO_BASE, default 'hFF80: first byte address of the IO window; addresses >= IO_BASE are IO, all lower addresses are RAM.
REQ-004 Parameter IO_WAIT, default 2, range 0..15: extra IO strobe cycles.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 req  in  1  CPU access request; sampled only in IDLE.
REQ-008 we  in  1  1=write, 0=read; qualified by req.
REQ-009 be  in  1  1=byte access, 0=word access.
REQ-010 addr  in  AW  CPU byte address.
REQ-011 wdata  in  DW  CPU write data; byte writes use wdata[7:0].
REQ-012 rdata  out  DW  registered read data.
REQ-013 ready  out  1  one-cycle completion pulse.
REQ-014 err  out  1  one-cycle error pulse, coincident with ready; present only with MEM_BUS_ALIGN_CHK_EN.
REQ-015 ram_addr  out  AW  RAM word address = {1'b0, addr[AW-1:1]}.
REQ-016 ram_wdata / ram_rdata  out / in  DW  RAM data; RAM has 1-cycle read latency.
REQ-017 ram_be  out  2  {high-byte, low-byte} write enables.
REQ-018 ram_we / ram_re  out  1  RAM strobes.
REQ-019 io_addr  out  3  = latched addr[2:0].
REQ-020 io_wdata / io_rdata  out / in  8  IO byte data.
REQ-021 io_ce / io_we / io_re  out  1  IO strobes.

Function
REQ-022 FSM states are IDLE, RAM, IO and DONE; in IDLE with req=1, latch addr/we/be/wdata and go to RAM or IO by window.
REQ-023 RAM state lasts 1 cycle with ram_re=!we and ram_we=we, then DONE; ram_rdata is captured on the RAM->DONE edge.
REQ-024 IO state lasts IO_WAIT+1 cycles with io_ce=1, io_we=we and io_re=!we; io_rdata is captured on the last edge.
REQ-025 DONE lasts 1 cycle with ready=1, then IDLE; req during RAM/IO/DONE is ignored and must be held by the CPU until IDLE.
REQ-026 Latency from the accepting edge to ready high: RAM=2 cycles, IO=IO_WAIT+2 cycles.
REQ-027 Byte write, odd address: ram_wdata = {0, wdata[7:0]} with ram_be=01; even address: wdata[7:0] goes to bits [15:8] with ram_be=10.
REQ-028 Word write: ram_be=11 and ram_wdata=wdata.
REQ-029 Byte read: odd address returns ram_rdata[7:0], even address returns ram_rdata[15:8], zero-extended to DW; word read returns ram_rdata.
REQ-030 IO reads return {0, io_rdata}, and IO writes drive io_wdata = wdata[7:0], regardless of be.
REQ-031 All strobes are 0 outside their state; rdata holds its value until the next read completes; writes leave rdata unchanged.
REQ-032 Address IO_BASE-1 is RAM; IO_BASE and 2^AW-1 are IO.

Reset
REQ-033 rst_n low, at any time including mid-access: state=IDLE, and rdata, ready, err and all RAM/IO strobes are 0 immediately; ram_be=00.
REQ-034 The first req is accepted on the first rising edge with rst_n high.

Configuration
REQ-035 MEM_BUS_ALIGN_CHK_EN defined: a word access to an odd address goes IDLE->DONE without RAM/IO strobes, with ready=1 and err=1 and rdata unchanged.
REQ-036 MEM_BUS_ALIGN_CHK_EN undefined: there is no err port, and a word access to an odd address is performed with addr[0] ignored.

Verification
REQ-037 Word write 0x1234 to 0x0010, then word read 0x0010 -> ram_addr=0x0008, ram_be=11; ready 2 cycles after accept; rdata=0x1234.
REQ-038 Byte write 0xAB to 0x0011, then byte read 0x0011 and 0x0010 with RAM word 0x56AB -> ram_be=01; rdata=0x00AB, then 0x0056.
REQ-039 IO_WAIT=2: read 0xFF85 with io_rdata=0x7E -> io_addr=5, io_ce high 3 cycles; ready at accept+4; rdata=0x007E.
REQ-040 Reset asserted during the 2nd IO cycle -> io_ce=0 and ready=0 immediately; a new RAM read after release completes normally.
REQ-041 With MEM_BUS_ALIGN_CHK_EN: word read 0x0003 -> no ram_re, ready=err=1 at accept+1, rdata unchanged.
